// File: rtl/shared_pkg.sv
// Shared AHB5 types and bus widths for the subordinate memory slice.
//   ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH : bus widths (STRB_WIDTH = DATA_WIDTH/8)
//   htrans_e, hburst_e, hsize_e, type_e : AHB5 transfer attribute encodings
//   sub_state_e : subordinate data-phase FSM states
package shared_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic {
    TYPE_READ  = 1'b0,
    TYPE_WRITE = 1'b1
  } type_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } sub_state_e;

endpackage

// File: rtl/ahb5_sub_ram.sv
// Word RAM behind the AHB5 subordinate.
//   HCLK  : write clock (rising edge)
//   we    : write enable for this cycle
//   addr  : word index, shared by write and read port
//   wstrb : per-byte write enables
//   wdata : write data
//   rdata : asynchronous read of mem[addr]
// Contents are not reset.
module ahb5_sub_ram
  import shared_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  addr,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb5_sub_mem.sv
// AHB5 subordinate backed by a word RAM, with configurable wait states and
// two-cycle ERROR responses.
//   HCLK, HRESETn         : clock, asynchronous active-low reset
//   HSEL1, HREADY         : select and bus ready (accept qualifiers)
//   HADDR, HTRANS, HWRITE : address-phase attributes
//   HSIZE                 : only used for error checks
//   HBURST                : informational, not decoded
//   HWDATA, HWSTRB        : data-phase write data and byte strobes
//   HRDATA                : read data, 0 outside a read data phase
//   HREADYOUT, HRESP      : transfer done and OKAY/ERROR response
// Build option: define AHB5_SUB_ERROR_RESP_EN to enable ERROR responses for
// out-of-range, oversized or misaligned accesses. Without it HRESP is tied 0
// and the word index wraps modulo MEM_DEPTH.
module ahb5_sub_mem
  import shared_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL1,
  input  logic                  HREADY,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  hburst_e               HBURST,
  input  hsize_e                HSIZE,
  input  htrans_e               HTRANS,
  input  type_e                 HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [STRB_WIDTH-1:0] HWSTRB,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned OFS_W   = $clog2(STRB_WIDTH);
  localparam logic [2:0]  WS_INIT = 3'(WAIT_STATES);

  sub_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [2:0]            wait_q, wait_d;
  logic                  accept;
  logic                  addr_err;
  logic                  take_new;
  logic                  resp_fsm;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept = HSEL1 && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef AHB5_SUB_ERROR_RESP_EN
  logic [7:0] size_mask;
  always_comb begin
    size_mask = (8'd1 << HSIZE) - 8'd1;
    addr_err  = (|HADDR[ADDR_WIDTH-1:OFS_W+IDX_W]) ||
                (3'(HSIZE) > 3'(OFS_W)) ||
                (|(HADDR[7:0] & size_mask));
  end
  assign HRESP = resp_fsm;
  logic unused_bits;
  assign unused_bits = ^{HBURST};
`else
  assign addr_err = 1'b0;
  assign HRESP    = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{HBURST, HSIZE, HADDR, resp_fsm};
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wait_q  <= wait_d;
    end
  end

  // S_DATA and S_ERR2 both end with HREADYOUT high, so a new address phase
  // can be accepted there exactly as from S_IDLE (take_new).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wait_d    = wait_q;
    HREADYOUT = 1'b1;
    resp_fsm  = 1'b0;
    ram_we    = 1'b0;
    take_new  = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_new = 1'b1;
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        wait_d    = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        ram_we   = write_q;
        state_d  = S_IDLE;
        take_new = 1'b1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        resp_fsm  = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        resp_fsm = 1'b1;
        state_d  = S_IDLE;
        take_new = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_new && accept) begin
      idx_d   = HADDR[OFS_W +: IDX_W];
      write_d = HWRITE;
      if (addr_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES != 0) begin
        state_d = S_WAIT;
        wait_d  = WS_INIT;
      end else begin
        state_d = S_DATA;
      end
    end
  end

  // Read is combinational from the registered index, so a read following a
  // write sees the value committed at the edge that closed the write.
  assign HRDATA = ((state_q == S_DATA) && !write_q) ? ram_rdata : '0;

  ahb5_sub_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_WIDTH (IDX_W)
  ) u_ram (
    .HCLK  (HCLK),
    .we    (ram_we),
    .addr  (idx_q),
    .wstrb (HWSTRB),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

endmodule
